// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin scheduler sharing one serial binary-to-BCD converter
//
// Watches NUM_CH binary channel values. A channel is pending when its value differs from the
// last value it converted, or when a refresh has forced it. Pending channels are granted the
// converter in round-robin order. The scheduler drives the converter with a start/done handshake
// and stores each channel's 3-digit BCD result.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   ch_value           packed binary inputs, channel k at [8k+7:8k]
//   refresh            pulse: reconvert every channel, clear timeout_err
//   conv_start         one-cycle start pulse to the converter
//   conv_value         operand, held from start until done/timeout
//   conv_done          converter completion pulse, digits valid in that cycle
//   conv_hundreds/tens/ones  converter result digits
//   bcd_out            per-channel {hundreds,tens,ones}, channel k at [12k+11:12k]
//   ch_updated         one-cycle pulse on bit k when bcd_out slice k is written
//   busy               high whenever the FSM is not idle
//   timeout_err        sticky converter-timeout flag
module bcd_convert_scheduler #(
   parameter int NUM_CH  = 3,
   parameter int TIMEOUT = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH*8-1:0]   ch_value,
   input  logic                  refresh,
   output logic                  conv_start,
   output logic [7:0]            conv_value,
   input  logic                  conv_done,
   input  logic [3:0]            conv_hundreds,
   input  logic [3:0]            conv_tens,
   input  logic [3:0]            conv_ones,
   output logic [NUM_CH*12-1:0]  bcd_out,
   output logic [NUM_CH-1:0]     ch_updated,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int CW = $clog2(NUM_CH);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

   state_t                  state, state_nx;
   logic [NUM_CH-1:0][7:0]  snap;
   logic [NUM_CH-1:0]       force_flag;
   logic [NUM_CH-1:0]       pending;
   logic [CW-1:0]           rr;
   logic [CW-1:0]           gnt;
   logic [CW-1:0]           sel;
   logic [CW-1:0]           sel_next;
   logic                    any_pending;
   logic [TW-1:0]           cnt;
   logic [11:0]             digits;
   logic                    grant_en;
   logic                    capture_en;
   logic                    store_en;
   logic                    tmo_hit;

   always_comb begin
      pending = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         pending[k] = (ch_value[8*k +: 8] != snap[k]) | force_flag[k];
      end
   end

   // First pending channel searching upward from rr, wrapping modulo NUM_CH.
   always_comb begin
      int            idx;
      logic [CW-1:0] idx_c;
      idx         = 0;
      idx_c       = '0;
      any_pending = 1'b0;
      sel         = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr) + i;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         idx_c = CW'(idx);
         if (!any_pending && pending[idx_c]) begin
            any_pending = 1'b1;
            sel         = idx_c;
         end
      end
   end

   assign sel_next = (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;

   always_comb begin
      state_nx   = state;
      grant_en   = 1'b0;
      capture_en = 1'b0;
      store_en   = 1'b0;
      tmo_hit    = 1'b0;
      conv_start = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (any_pending) begin
               grant_en = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            conv_start = 1'b1;
            state_nx   = WAIT;
         end
         WAIT: begin
            if (conv_done) begin
               capture_en = 1'b1;
               state_nx   = STORE;
            end else if (cnt == TW'(TIMEOUT - 2)) begin
               // The counter would reach TIMEOUT-1 on this edge: abandon the conversion.
               tmo_hit  = 1'b1;
               state_nx = IDLE;
            end
         end
         STORE: begin
            store_en = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr          <= '0;
         gnt         <= '0;
         snap        <= '0;
         force_flag  <= '0;
         cnt         <= '0;
         digits      <= '0;
         conv_value  <= '0;
         bcd_out     <= '0;
         ch_updated  <= '0;
         timeout_err <= 1'b0;
      end else begin
         state      <= state_nx;
         ch_updated <= '0;
         if (grant_en) begin
            gnt             <= sel;
            conv_value      <= ch_value[8*sel +: 8];
            force_flag[sel] <= 1'b0;
            rr              <= sel_next;
         end
         if (conv_start) begin
            cnt <= '0;
         end else if (state == WAIT && !conv_done) begin
            cnt <= cnt + 1'b1;
         end
         if (capture_en) begin
            digits <= {conv_hundreds, conv_tens, conv_ones};
         end
         // Result and its update strobe are registered together so they appear in the same cycle.
         if (store_en) begin
            bcd_out[12*gnt +: 12] <= digits;
            snap[gnt]             <= conv_value;
            ch_updated[gnt]       <= 1'b1;
         end
         if (tmo_hit) begin
            timeout_err <= 1'b1;
         end
         // Placed last so a refresh in a grant cycle re-forces the just-granted channel.
         if (refresh) begin
            force_flag  <= '1;
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb/tb_bcd_convert_scheduler.sv - scoreboard bench for bcd_convert_scheduler
module tb_bcd_convert_scheduler;

   localparam int N   = 3;
   localparam int TMO = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N*8-1:0] ch_value = '0;
   logic           refresh = 1'b0;
   logic           conv_start;
   logic [7:0]     conv_value;
   logic           conv_done = 1'b0;
   logic [3:0]     conv_hundreds = '0;
   logic [3:0]     conv_tens = '0;
   logic [3:0]     conv_ones = '0;
   logic [N*12-1:0] bcd_out;
   logic [N-1:0]   ch_updated;
   logic           busy;
   logic           timeout_err;

   always #5 clk = ~clk;

   bcd_convert_scheduler #(.NUM_CH(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ch_value(ch_value), .refresh(refresh),
      .conv_start(conv_start), .conv_value(conv_value), .conv_done(conv_done),
      .conv_hundreds(conv_hundreds), .conv_tens(conv_tens), .conv_ones(conv_ones),
      .bcd_out(bcd_out), .ch_updated(ch_updated), .busy(busy), .timeout_err(timeout_err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [11:0] to_bcd(input logic [7:0] v);
      int x;
      x = int'(v);
      return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   // Reference model state
   typedef struct {
      int         ch;
      logic [7:0] val;
      int         start;
      int         d;
   } exp_t;

   logic [7:0]  m_snap [N];
   bit          m_force [N];
   logic [11:0] m_bcd [N];
   logic [7:0]  last_ch [N];
   int          m_rr = 0;
   bit          m_err = 0;
   bit          outstanding = 0;
   int          tmo_due = -1;
   int          n_starts = 0;
   int          last_lat = 0;
   exp_t        q[$];
   int          grant_log[$];
   int          upd_ch_log[$];
   logic [11:0] upd_bcd_log[$];

   // Converter behaviour controls
   bit          conv_en = 1'b1;
   int          d_fixed = 0;
   int          cur_d = 1;
   bit          cur_resp = 1'b1;

   function automatic bit quiet();
      bit p;
      p = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (ch_value[8*k +: 8] != m_snap[k] || m_force[k]) p = 1'b1;
      end
      return (q.size() == 0) && !outstanding && !p;
   endfunction

   // Behavioural converter: answers D cycles after the start pulse when enabled.
   initial begin : converter
      int         cd;
      logic [7:0] cv;
      cd = 0;
      cv = '0;
      forever begin
         @(posedge clk);
         #2;
         conv_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               conv_done = 1'b1;
               {conv_hundreds, conv_tens, conv_ones} = to_bcd(cv);
            end
         end
         if (conv_start) begin
            cur_resp = conv_en;
            if (conv_en) begin
               cur_d = (d_fixed > 0) ? d_fixed : int'($urandom_range(1, 12));
               cd    = cur_d;
               cv    = conv_value;
            end
         end
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin : monitor
      int   g;
      int   k;
      exp_t e;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_snap[i]  = '0;
            m_force[i] = 1'b0;
            m_bcd[i]   = '0;
            last_ch[i] = ch_value[8*i +: 8];
         end
         m_rr        = 0;
         m_err       = 1'b0;
         outstanding = 1'b0;
         tmo_due     = -1;
         q.delete();
      end else begin
         check("updated_onehot", 64'($onehot0(ch_updated)), 64'd1);
         if (conv_start) begin
            n_starts++;
            check("start_while_outstanding", 64'(outstanding), 64'd0);
            g = -1;
            for (int i = 0; i < N; i++) begin
               k = (m_rr + i) % N;
               if (g < 0 && (last_ch[k] != m_snap[k] || m_force[k])) g = k;
            end
            if (g < 0) begin
               fail_now("grant: conv_start with no pending channel");
            end else begin
               check("conv_value", 64'(conv_value), 64'(last_ch[g]));
               grant_log.push_back(g);
               m_force[g]  = 1'b0;
               m_rr        = (g + 1) % N;
               outstanding = 1'b1;
               if (cur_resp) begin
                  e.ch    = g;
                  e.val   = last_ch[g];
                  e.start = cyc;
                  e.d     = cur_d;
                  q.push_back(e);
               end else begin
                  tmo_due = cyc + TMO;
               end
            end
         end
         if (ch_updated != '0) begin
            if (q.size() == 0) begin
               fail_now("unexpected ch_updated");
            end else begin
               e = q.pop_front();
               check("updated_ch", 64'(ch_updated), 64'(1 << e.ch));
               last_lat = cyc - e.start;
               check("update_latency", 64'(last_lat), 64'(e.d + 2));
               m_bcd[e.ch]  = to_bcd(e.val);
               m_snap[e.ch] = e.val;
               check("bcd_out", 64'(bcd_out), 64'({m_bcd[2], m_bcd[1], m_bcd[0]}));
               upd_ch_log.push_back(e.ch);
               upd_bcd_log.push_back(bcd_out[12*e.ch +: 12]);
               outstanding = 1'b0;
            end
         end
         if (cyc == tmo_due) begin
            m_err       = 1'b1;
            outstanding = 1'b0;
            tmo_due     = -1;
         end
         check("timeout_err", 64'(timeout_err), 64'(m_err));
         if (refresh) begin
            for (int i = 0; i < N; i++) m_force[i] = 1'b1;
            m_err = 1'b0;
         end
         for (int i = 0; i < N; i++) last_ch[i] = ch_value[8*i +: 8];
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_quiet(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if (quiet() && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now({"wait_quiet timed out: ", name});
   endtask

   task automatic wait_start(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (conv_start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now({"wait_start timed out: ", name});
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      ch_value = '0;
      tick(3);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int starts0;
      int k;
      tick(1);
      do_reset();

      // Idle after reset with all-zero inputs
      tick(20);
      check("idle_no_start", 64'(n_starts), 64'd0);
      check("idle_bcd_out", 64'(bcd_out), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // Single conversion, D = 9
      d_fixed  = 9;
      starts0  = n_starts;
      ch_value[7:0] = 8'd59;
      wait_quiet("sec59");
      check("sec59_starts", 64'(n_starts - starts0), 64'd1);
      check("sec59_bcd", 64'(bcd_out[11:0]), 64'h059);
      check("sec59_latency", 64'(last_lat), 64'd11);

      // All three channels change together
      do_reset();
      d_fixed = 3;
      grant_log.delete();
      ch_value = {8'd12, 8'd30, 8'd45};
      wait_quiet("all3");
      check("all3_grants_n", 64'(grant_log.size()), 64'd3);
      if (grant_log.size() == 3) begin
         check("all3_grant0", 64'(grant_log[0]), 64'd0);
         check("all3_grant1", 64'(grant_log[1]), 64'd1);
         check("all3_grant2", 64'(grant_log[2]), 64'd2);
      end
      check("all3_bcd", 64'(bcd_out), 64'({12'h012, 12'h030, 12'h045}));
      grant_log.delete();
      ch_value[7:0] = 8'd46;
      wait_quiet("sec46");
      check("sec46_grants_n", 64'(grant_log.size()), 64'd1);
      if (grant_log.size() == 1) check("sec46_grant", 64'(grant_log[0]), 64'd0);

      // Value changes during WAIT
      d_fixed = 9;
      upd_ch_log.delete();
      upd_bcd_log.delete();
      ch_value[15:8] = 8'd7;
      wait_start("min07");
      tick(3);
      ch_value[15:8] = 8'd8;
      wait_quiet("min08");
      check("midchange_updates", 64'(upd_ch_log.size()), 64'd2);
      if (upd_ch_log.size() == 2) begin
         check("midchange_ch_a", 64'(upd_ch_log[0]), 64'd1);
         check("midchange_bcd_a", 64'(upd_bcd_log[0]), 64'h007);
         check("midchange_ch_b", 64'(upd_ch_log[1]), 64'd1);
         check("midchange_bcd_b", 64'(upd_bcd_log[1]), 64'h008);
      end

      // Timeout and retry
      conv_en = 1'b0;
      grant_log.delete();
      ch_value[23:16] = 8'd99;
      wait_start("tmo");
      tick(31);
      check("tmo_err_before", 64'(timeout_err), 64'd0);
      tick(1);
      check("tmo_err_rise", 64'(timeout_err), 64'd1);
      conv_en = 1'b1;
      wait_quiet("tmo_retry");
      check("tmo_grants_n", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() == 2) begin
         check("tmo_grant_first", 64'(grant_log[0]), 64'd2);
         check("tmo_grant_retry", 64'(grant_log[1]), 64'd2);
      end
      check("tmo_retry_bcd", 64'(bcd_out[35:24]), 64'h099);
      check("tmo_err_sticky", 64'(timeout_err), 64'd1);

      // Refresh reconverts everything and clears the error
      grant_log.delete();
      refresh = 1'b1;
      tick(1);
      refresh = 1'b0;
      wait_quiet("refresh");
      check("refresh_err_clear", 64'(timeout_err), 64'd0);
      check("refresh_grants_n", 64'(grant_log.size()), 64'd3);
      check("refresh_bcd", 64'(bcd_out), 64'({12'h099, 12'h008, 12'h046}));

      // Randomized traffic
      d_fixed = 0;
      for (int it = 0; it < 300; it++) begin
         tick(int'($urandom_range(0, 6)));
         k = int'($urandom_range(0, N - 1));
         ch_value[8*k +: 8] = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) begin
            wait_quiet("rand_pre_refresh");
            refresh = 1'b1;
            tick(1);
            refresh = 1'b0;
         end
      end
      wait_quiet("rand_end");
      check("rand_final_bcd", 64'(bcd_out),
            64'({to_bcd(ch_value[23:16]), to_bcd(ch_value[15:8]), to_bcd(ch_value[7:0])}));

      // Reset during WAIT; the later conv_done must be ignored
      do_reset();
      d_fixed = 9;
      ch_value[7:0] = 8'd77;
      wait_start("rst_wait");
      tick(2);
      rst_n    = 1'b0;
      ch_value = '0;
      tick(1);
      rst_n   = 1'b1;
      starts0 = n_starts;
      tick(15);
      check("rstwait_bcd", 64'(bcd_out), 64'd0);
      check("rstwait_busy", 64'(busy), 64'd0);
      check("rstwait_no_start", 64'(n_starts - starts0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_convert_scheduler.md
# bcd_convert_scheduler

Shares one serial binary-to-BCD converter between the clock's NUM_CH display channels (seconds, minutes, hours). It detects which channel values have changed and grants the converter round-robin. It drives the converter through a start/done handshake and keeps the converted 3-digit BCD result for each channel. It sits between the timekeeping counters and the seven-segment display mux.

## Interface
- NUM_CH, 3: number of requesting channels (2..8); channel 0 = seconds, 1 = minutes, 2 = hours.
- TIMEOUT, 32: cycles to wait for conv_done before abandoning a conversion (≥ 12).

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ch_value  in  NUM_CH*8  binary value per channel; channel k is [8k+7:8k].
- refresh  in  1  one-cycle pulse; forces every channel to reconvert.
- conv_start  out  1  one-cycle pulse to the converter: begin converting conv_value.
- conv_value  out  8  operand to the converter; held stable from the start pulse until done or timeout.
- conv_done  in  1  one-cycle pulse from the converter; conv_hundreds/tens/ones are valid in that cycle.
- conv_hundreds, conv_tens, conv_ones  in  4 each  converter result digits.
- bcd_out  out  NUM_CH*12  per-channel result {hundreds, tens, ones}; channel k is [12k+11:12k].
- ch_updated  out  NUM_CH  one-cycle pulse on bit k when bcd_out slice k is written.
- busy  out  1  high in every state other than IDLE.
- timeout_err  out  1  sticky; set on a timeout, cleared by reset or refresh.

## Operation
- Per-channel register snap[k] (8 bit) holds the value last converted for channel k. A per-channel force[k] flag is set by refresh.
- pending[k] = (ch_value[k] != snap[k]) | force[k].
- Round-robin pointer rr is 0 after reset. The search order starts at rr and wraps modulo NUM_CH. The first pending channel is granted.
- After a grant to channel g, rr = (g+1) mod NUM_CH.
- FSM states: IDLE, ISSUE, WAIT, STORE.
  - IDLE: if any channel is pending, latch g and conv_value = ch_value[g], clear force[g], and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: conv_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: if conv_done, capture the three digits and go to STORE. Otherwise increment the counter. When the counter reaches TIMEOUT-1 without conv_done, set timeout_err and return to IDLE. In that case snap[g] is not updated, so the channel stays pending and is retried in round-robin order.
  - STORE: bcd_out slice g = captured digits; snap[g] = latched conv_value; ch_updated[g] = 1 for this cycle; go to IDLE.
- If ch_value[g] changes during a conversion, the old value finishes normally. snap then differs from the input, so the channel re-requests.
- conv_done seen in IDLE, ISSUE or STORE is ignored.
- Digits are stored as received, with no BCD validity check.
- A refresh pulse in the same cycle as a grant:
  - the grant clears force[g] first;
  - refresh then sets force on all channels, including g, which therefore converts twice;
  - timeout_err is cleared.

## Timing
- Reset values:
  - state IDLE, rr = 0, snap = 0, force = 0, counter = 0;
  - conv_start = 0, conv_value = 0, bcd_out = 0, ch_updated = 0, busy = 0, timeout_err = 0.
- Because snap resets to 0, a value of 0 after reset is not pending.
- Reset asserted mid-conversion:
  - returns to IDLE on that edge;
  - conv_start is low from the next cycle;
  - a later conv_done is ignored.
- Latency:
  - ch_value changes at edge E, so the grant is taken at E+1 and conv_start is high in the cycle after E+1.
  - With converter latency D (cycles from the start pulse to the done pulse), bcd_out and ch_updated appear D+2 cycles after the start pulse.
- Minimum spacing between two conversions is 4 cycles (IDLE, ISSUE, WAIT, STORE), with D = 1.
- conv_start never asserts while a conversion is outstanding.
- At most one ch_updated bit is high in any cycle.

## Test plan
- Reset with ch_value = {8'd0, 8'd0, 8'd0}, then hold for 20 cycles. Required: no conv_start, bcd_out = 0, busy = 0.
- Set the seconds channel to 8'd59 with a behavioural converter of D = 9. Required:
  - conv_value = 59 with a single start pulse;
  - bcd_out[11:0] = 12'h059;
  - ch_updated = 3'b001 exactly 11 cycles after the start pulse (D+2).
- Change all three channels in one cycle to 45/30/12. Required:
  - grants in order 0, 1, 2;
  - final bcd_out = {12'h012, 12'h030, 12'h045}.
  - Then change only channel 0 to 46: the next grant is channel 0.
- Change channel 1 to 07, then during WAIT change it to 08. Required:
  - bcd_out slice 1 first reads 12'h007;
  - a second conversion follows, giving 12'h008.
- Hold conv_done low with TIMEOUT = 32. Required:
  - timeout_err rises 32 cycles after the start pulse;
  - the same channel is retried.
  - Enable the converter: the retried conversion completes; timeout_err stays high until a refresh pulse.
- Assert rst_n low in WAIT, then pulse conv_done after release. Required: the pulse is ignored and bcd_out = 0.
